// File: rtl/free_tag_list_l9.sv
// Free tag list: circular buffer of rename tags. Reset preloads it with INIT_BASE..INIT_BASE+DEPTH-1,
// the oldest tag is offered on alloc_*, and retired tags are appended through free_*.
module free_tag_list_l9 #(
  parameter int LENGTH    = 9,
  parameter int DEPTH     = 16,
  parameter int INIT_BASE = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_ready,
  output logic                     alloc_valid,
  output logic [LENGTH-1:0]        alloc_tag,
  input  logic                     free_valid,
  input  logic [LENGTH-1:0]        free_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LENGTH-1:0] entries [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count_q;
  logic              ovf_q;

  logic              do_alloc;
  logic              do_free;
  logic              drop;
  logic              is_full;
  logic              is_empty;

  // A release is still accepted when full if an allocation frees a slot on the same edge.
  always_comb begin
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == '0);
    do_alloc = !is_empty && alloc_ready;
    do_free  = free_valid && (!is_full || do_alloc);
    drop     = free_valid && !do_free;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= LENGTH'(INIT_BASE + i);
      end
    end else if (do_free) begin
      entries[tail] <= free_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_alloc) begin
        head <= head + PW'(1);
      end
      if (do_free) begin
        tail <= tail + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CW'(DEPTH);
    end else begin
      case ({do_alloc, do_free})
        2'b10:   count_q <= count_q - CW'(1);
        2'b01:   count_q <= count_q + CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky until reset so a dropped return is never lost to software.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  always_comb begin
    alloc_valid  = !is_empty;
    alloc_tag    = entries[head];
    count        = count_q;
    full         = is_full;
    empty        = is_empty;
    overflow_err = ovf_q;
  end

endmodule

// File: tb/tb_free_tag_list_l9.sv
// Self-checking bench for free_tag_list_l9: directed vector table, an asynchronous
// mid-cycle reset sequence, and randomized traffic checked against a queue model.
module tb_free_tag_list_l9;

  localparam int LENGTH    = 9;
  localparam int DEPTH     = 16;
  localparam int INIT_BASE = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alloc_ready = 1'b0;
  logic              alloc_valid;
  logic [LENGTH-1:0] alloc_tag;
  logic              free_valid = 1'b0;
  logic [LENGTH-1:0] free_tag = '0;
  logic [4:0]        count;
  logic              full;
  logic              empty;
  logic              overflow_err;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit rst;
    bit ar;
    bit fv;
    int ft;
    bit ev;
    int et;
    int ec;
    bit eo;
  } vec_t;

  vec_t vecs[$];
  int   model_q[$];
  bit   model_ovf;

  always #5 clk = ~clk;

  free_tag_list_l9 #(
    .LENGTH(LENGTH), .DEPTH(DEPTH), .INIT_BASE(INIT_BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_ready(alloc_ready), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .free_valid(free_valid), .free_tag(free_tag),
    .count(count), .full(full), .empty(empty), .overflow_err(overflow_err)
  );

  function automatic vec_t mk(bit rst, bit ar, bit fv, int ft, bit ev, int et, int ec, bit eo);
    vec_t v;
    v.rst = rst; v.ar = ar; v.fv = fv; v.ft = ft;
    v.ev = ev; v.et = et; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic check_one(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_output(string name, bit ev, int et, int ec, bit eo);
    check_one({name, " alloc_valid"}, int'(alloc_valid), int'(ev));
    if (ev) check_one({name, " alloc_tag"}, int'(alloc_tag), et);
    check_one({name, " count"}, int'(count), ec);
    check_one({name, " full"}, int'(full), int'(ec == DEPTH));
    check_one({name, " empty"}, int'(empty), int'(ec == 0));
    check_one({name, " overflow_err"}, int'(overflow_err), int'(eo));
  endtask

  task automatic apply_stimulus(bit ar, bit fv, int ft);
    alloc_ready = ar;
    free_valid  = fv;
    free_tag    = LENGTH'(ft);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset       = 1'b0;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    #3;
    reset = 1'b1;
    @(negedge clk);
    model_q.delete();
    for (int i = 0; i < DEPTH; i++) model_q.push_back(INIT_BASE + i);
    model_ovf = 1'b0;
  endtask

  task automatic model_step(bit ar, bit fv, int ft);
    bit alloc;
    bit accept;
    alloc  = ar && (model_q.size() != 0);
    accept = fv && ((model_q.size() < DEPTH) || alloc);
    if (alloc) void'(model_q.pop_front());
    if (accept) model_q.push_back(ft);
    if (fv && !accept) model_ovf = 1'b1;
  endtask

  initial begin
    int pa;
    int pf;

    // Idle after reset, then drain all 16 tags and try to allocate from empty.
    vecs.push_back(mk(1, 0, 0, 0, 1, 32, 16, 0));
    for (int k = 0; k < 16; k++) vecs.push_back(mk(0, 1, 0, 0, k < 15, 33 + k, 15 - k, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // Free into empty while alloc_ready is high: no bypass, tag offered the next cycle.
    vecs.push_back(mk(0, 1, 1, 'h1A5, 1, 'h1A5, 1, 0));
    // Simultaneous alloc and free while full, then follow the freed tag to the head.
    vecs.push_back(mk(1, 1, 1, 'h0C3, 1, 33, 16, 0));
    for (int j = 0; j < 15; j++) vecs.push_back(mk(0, 1, 0, 0, 1, (j < 14) ? 34 + j : 'h0C3, 15 - j, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // Free while full without alloc: dropped, sticky error; then allocate 5 and free 3.
    vecs.push_back(mk(1, 0, 1, 'h055, 1, 32, 16, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 33 + i, 15 - i, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 'h100 + i, 1, 37, 12 + i, 1));

    @(negedge clk);
    pulse_reset();
    check_output("reset", 1, 32, 16, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        pulse_reset();
        check_output($sformatf("vec%0d pre-reset", i), 1, 32, 16, 0);
      end
      apply_stimulus(vecs[i].ar, vecs[i].fv, vecs[i].ft);
      check_output($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, vecs[i].ec, vecs[i].eo);
    end

    // Reset pulsed between clock edges must take effect without a clock.
    #2;
    reset       = 1'b0;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    #1;
    check_output("async_reset", 1, 32, 16, 0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("post_release", 1, 32, 16, 0);
    apply_stimulus(1, 0, 0);
    check_output("first_alloc", 1, 33, 15, 0);

    pulse_reset();
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(2))
        0:       pa = 20;
        1:       pa = 50;
        default: pa = 80;
      endcase
      case ($urandom_range(2))
        0:       pf = 20;
        1:       pf = 50;
        default: pf = 80;
      endcase
      for (int c = 0; c < 100; c++) begin
        bit ar;
        bit fv;
        int ft;
        ar = ($urandom_range(99) < pa);
        fv = ($urandom_range(99) < pf);
        ft = int'($urandom_range(511));
        model_step(ar, fv, ft);
        apply_stimulus(ar, fv, ft);
        check_output("random", model_q.size() != 0,
                     (model_q.size() != 0) ? model_q[0] : 0,
                     model_q.size(), model_ovf);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/free_tag_list_l9.md
FREE_TAG_LIST_L9 -- requirements
Module: free_tag_list_l9

Interface
REQ-001 The block SHALL expose parameter LENGTH, default 9, tag width in bits.
REQ-002 The block SHALL expose parameter DEPTH, default 16, number of tag slots (power of two, 2..256).
REQ-003 The block SHALL expose parameter INIT_BASE, default 32, first tag loaded at reset.
REQ-004 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port alloc_ready, input, 1, downstream rename register takes the offered tag this cycle.
REQ-007 The block SHALL have port alloc_valid, output, 1, a free tag is offered.
REQ-008 The block SHALL have port alloc_tag, output, LENGTH, offered tag (oldest free entry).
REQ-009 The block SHALL have port free_valid, input, 1, a retired tag is returned this cycle.
REQ-010 The block SHALL have port free_tag, input, LENGTH, tag being returned.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1, number of free tags held.
REQ-012 The block SHALL have ports full and empty, output, 1 each, count==DEPTH and count==0.
REQ-013 The block SHALL have port overflow_err, output, 1, sticky illegal-return flag.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH LENGTH-bit entries with head (read) and tail (write) pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-015 alloc_valid SHALL equal (count != 0) and alloc_tag SHALL equal entry[head], both driven from registered state only, with no combinational path from any input.
REQ-016 An allocation SHALL occur on a rising clk edge where alloc_valid=1 and alloc_ready=1: head increments, and count decrements unless a release also occurs.
REQ-017 alloc_ready while alloc_valid=0 SHALL have no effect.
REQ-018 A release SHALL be accepted on a rising clk edge where free_valid=1 and (count<DEPTH or an allocation occurs the same edge): free_tag is written to entry[tail], tail increments, and count increments unless an allocation also occurs.
REQ-019 Simultaneous allocation and release SHALL leave count unchanged and move both pointers.
REQ-020 A returned tag SHALL never bypass to alloc_tag in the same cycle; when empty, a tag freed at edge N SHALL be offered from edge N onward (alloc_valid=1 in cycle N+1).
REQ-021 free_valid with full=1 and no same-edge allocation SHALL be dropped: no pointer, entry or count change, and overflow_err set to 1.
REQ-022 overflow_err SHALL remain 1 until reset.
REQ-023 Tag values SHALL be stored unmodified; the block SHALL NOT check for duplicate tags.

Reset
REQ-024 While reset=0, asynchronously: entry[i]=INIT_BASE+i for i=0..DEPTH-1, head=0, tail=0, count=DEPTH, full=1, empty=0, alloc_valid=1, alloc_tag=INIT_BASE, overflow_err=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight state and restore REQ-024 values regardless of clk.
REQ-026 On the first rising edge after reset releases, the block SHALL operate normally, so an allocation on that edge is honoured.

Verification
REQ-027 Reset, no activity -> count=16, full=1, alloc_valid=1, alloc_tag=32, overflow_err=0.
REQ-028 Hold alloc_ready=1 for 16 cycles -> alloc_tag sequence 32..47, then empty=1, alloc_valid=0, count=0; further alloc_ready has no effect.
REQ-029 From empty, free_valid=1 with free_tag=0x1A5 for one edge while alloc_ready=1 -> no allocation that edge; next cycle alloc_valid=1, alloc_tag=0x1A5, count=1.
REQ-030 From full, free_valid=1 and alloc_ready=1 on the same edge with free_tag=0x0C3 -> count stays 16, alloc_tag becomes 33, and 0x0C3 is offered after 15 more allocations.
REQ-031 From full, free_valid=1 with alloc_ready=0 -> count stays 16, entries unchanged, overflow_err=1 and stays 1 until reset.
REQ-032 Allocate 5, free 3 tags, then pulse reset=0 between clock edges -> outputs immediately return to REQ-027 values, and the tag sequence restarts at 32.
